frame_buffer_pingpong: RTL and testbench

FRAME_BUFFER_PINGPONG -- requirements
Module: frame_buffer_pingpong

---
 rtl/frame_buffer_pingpong.sv | 136 +++++++++++++
 tb/tb_frame_buffer_pingpong.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_pingpong.sv
// ---------------------------------------------------------------------------
// frame_buffer_pingpong
//   Double-buffered frame store. A producer fills the back bank while a
//   display reads the front bank. Once the producer marks the back bank
//   complete, the banks swap at the next display frame boundary.
//
//   Optional feature macro: FB_OVERRUN_CNT_EN
//     When defined, adds overrun_cnt. It counts cycles in which a write was
//     attempted while the back bank was locked, saturating at 0xFFFF.
//     When undefined, such writes are simply dropped.
//
// Ports
//   clk, rst         single rising-edge clock, async active-high reset
//   wr_en/addr/data  pixel write into the back bank
//   wr_frame_done    pulse: back bank complete, lock it until the swap
//   wr_ready         back bank accepts writes (FILL state)
//   rd_en/rd_addr    pixel read from the front bank, 1-cycle latency
//   rd_frame_start   pulse: display frame boundary, the swap point
//   rd_data/rd_valid read result
//   front_bank       bank currently displayed
//   frame_valid      at least one completed frame has been displayed
//   overrun_cnt      (FB_OVERRUN_CNT_EN only) dropped-write counter
// ---------------------------------------------------------------------------
module frame_buffer_pingpong #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int PIX_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [PIX_W-1:0]      wr_data,
    input  logic                  wr_frame_done,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_frame_start,
    output logic [PIX_W-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  front_bank,
`ifdef FB_OVERRUN_CNT_EN
    output logic [15:0]           overrun_cnt,
`endif
    output logic                  frame_valid
);

    localparam logic [ADDR_WIDTH:0] NPIX = (ADDR_WIDTH+1)'(WIDTH * HEIGHT);

    typedef enum logic {FILL, PENDING} state_e;

    state_e            state_q, state_d;
    logic              front_q, front_d;
    logic              fv_q, fv_d;
    logic              rd_valid_q;
    logic [PIX_W-1:0]  rd_data_q;

    // Both banks live in one array; the bank index is the address MSB.
    logic [PIX_W-1:0]  mem [2**(ADDR_WIDTH+1)];

    logic wr_fire;
    logic rd_hit;

    assign wr_ready    = (state_q == FILL);
    assign front_bank  = front_q;
    assign frame_valid = fv_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

    assign wr_fire = wr_en && wr_ready && ({1'b0, wr_addr} < NPIX);
    assign rd_hit  = fv_q && ({1'b0, rd_addr} < NPIX);

    // ---- bank-swap FSM ----
    always_comb begin
        state_d = state_q;
        front_d = front_q;
        fv_d    = fv_q;
        case (state_q)
            // A simultaneous rd_frame_start is ignored here: the bank only
            // becomes swappable from the cycle after it is locked.
            FILL:    if (wr_frame_done) state_d = PENDING;
            PENDING: if (rd_frame_start) begin
                state_d = FILL;
                front_d = ~front_q;
                fv_d    = 1'b1;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            front_q <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            fv_q    <= fv_d;
        end
    end

    // ---- storage: writes always target the back bank ----
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[{~front_q, wr_addr}] <= wr_data;
    end

    // Reads use the pre-edge front_q, so a read on the swap edge still
    // returns the outgoing front bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en)
                rd_data_q <= rd_hit ? mem[{front_q, rd_addr}] : '0;
        end
    end

`ifdef FB_OVERRUN_CNT_EN
    logic [15:0] ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovr_q <= '0;
        else if (wr_en && !wr_ready && (ovr_q != 16'hFFFF))
            ovr_q <= ovr_q + 16'd1;
    end

    assign overrun_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
module tb_frame_buffer_pingpong;

    localparam int AW   = 19;
    localparam int PW   = 24;
    localparam int NPIX = 640 * 480;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, wr_frame_done, rd_en, rd_frame_start;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [PW-1:0] wr_data;
    logic          wr_ready, rd_valid, front_bank, frame_valid;
    logic [PW-1:0] rd_data;
`ifdef FB_OVERRUN_CNT_EN
    logic [15:0]   overrun_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural model: banks as a sparse map keyed by {bank, addr}.
    logic [PW-1:0] mdl [int];
    bit            m_pend, m_front, m_fv, m_rvalid, m_known;
    logic [PW-1:0] m_rdata;
    int            m_ovr;

    frame_buffer_pingpong dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_frame_done  (wr_frame_done),
        .wr_ready       (wr_ready),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_frame_start (rd_frame_start),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .front_bank     (front_bank),
`ifdef FB_OVERRUN_CNT_EN
        .overrun_cnt    (overrun_cnt),
`endif
        .frame_valid    (frame_valid)
    );

    always #5 clk = ~clk;

    function automatic int key(bit b, int a);
        return (int'(b) << 20) | a;
    endfunction

    task automatic idle();
        wr_en = 0; wr_frame_done = 0; rd_en = 0; rd_frame_start = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    task automatic model_reset();
        mdl.delete();
        m_pend = 0; m_front = 0; m_fv = 0; m_rvalid = 0;
        m_rdata = '0; m_known = 1; m_ovr = 0;
    endtask

    // Advance the model by the spec rules using the current inputs, then
    // clock the DUT and settle 1 time unit past the edge.
    task automatic tick();
        m_rvalid = rd_en;
        if (rd_en) begin
            if (!m_fv || int'(rd_addr) >= NPIX) begin
                m_rdata = '0; m_known = 1;
            end else if (mdl.exists(key(m_front, int'(rd_addr)))) begin
                m_rdata = mdl[key(m_front, int'(rd_addr))]; m_known = 1;
            end else begin
                m_known = 0;
            end
        end
        if (wr_en && !m_pend && int'(wr_addr) < NPIX)
            mdl[key(!m_front, int'(wr_addr))] = wr_data;
        if (wr_en && m_pend && m_ovr < 65535)
            m_ovr++;
        if (!m_pend) begin
            if (wr_frame_done) m_pend = 1;
        end else if (rd_frame_start) begin
            m_pend = 0; m_front = !m_front; m_fv = 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wr_ready, front_bank, frame_valid, rd_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=1000", {wr_ready, front_bank, frame_valid, rd_valid});
        end
        checks++;
        if (rd_data !== '0) begin
            failures++; $display("FAIL reset_rd_data got=%h want=0", rd_data);
        end
        #2 rst = 0;
        @(negedge clk);
    endtask

    // Read before any frame is displayed returns 0 with rd_valid one cycle later.
    task automatic test_first_read();
        rd_en = 1; rd_addr = 5;
        tick();
        rd_en = 0;
        checks++;
        if ({rd_valid, frame_valid, wr_ready} !== 3'b101 || rd_data !== '0) begin
            failures++;
            $display("FAIL first_read got v/fv/rdy=%b data=%h want=101 data=0", {rd_valid, frame_valid, wr_ready}, rd_data);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++; $display("FAIL rd_valid_drop got=%b want=0", rd_valid);
        end
    endtask

    task automatic test_write_swap();
        wr_en = 1; wr_addr = 5; wr_data = 24'hFF0000;
        tick();
        wr_en = 0; wr_frame_done = 1;
        tick();
        wr_frame_done = 0;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++; $display("FAIL pending_ready got=%b want=0", wr_ready);
        end
        rd_frame_start = 1;
        tick();
        rd_frame_start = 0;
        checks++;
        if ({front_bank, frame_valid, wr_ready} !== 3'b111) begin
            failures++;
            $display("FAIL swap_flags got=%b want=111", {front_bank, frame_valid, wr_ready});
        end
        rd_en = 1; rd_addr = 5;
        tick();
        rd_en = 0;
        checks++;
        if (rd_data !== 24'hFF0000 || rd_valid !== 1'b1) begin
            failures++; $display("FAIL read_swapped got=%h want=ff0000", rd_data);
        end
    endtask

    // Writes while PENDING must not reach the locked bank.
    task automatic test_pending_write();
        wr_en = 1; wr_addr = 5; wr_data = 24'h0000AA;
        tick();
        wr_data = 24'h00FF00; wr_frame_done = 1;   // written, then lock
        tick();
        wr_frame_done = 0;
        wr_data = 24'h123123;                      // dropped
        tick();
        wr_en = 0;
`ifdef FB_OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt !== 16'd1) begin
            failures++; $display("FAIL overrun_cnt got=%0d want=1", overrun_cnt);
        end
`endif
        rd_frame_start = 1;
        tick();
        rd_frame_start = 0;
        rd_en = 1; rd_addr = 5;
        tick();
        rd_en = 0;
        checks++;
        if (front_bank !== 1'b0 || rd_data !== 24'h00FF00) begin
            failures++;
            $display("FAIL pending_write_dropped got fb=%b data=%h want fb=0 data=00ff00", front_bank, rd_data);
        end
    endtask

    // done and start together: lock only, swap on the following start.
    task automatic test_simultaneous();
        wr_en = 1; wr_addr = 7; wr_data = 24'hABCDEF;   // bank 1
        tick();
        wr_en = 0; wr_frame_done = 1; rd_frame_start = 1;
        tick();
        wr_frame_done = 0; rd_frame_start = 0;
        checks++;
        if (wr_ready !== 1'b0 || front_bank !== 1'b0) begin
            failures++;
            $display("FAIL simult got rdy=%b fb=%b want rdy=0 fb=0", wr_ready, front_bank);
        end
        tick();
        rd_frame_start = 1;
        tick();
        rd_frame_start = 0;
        checks++;
        if (front_bank !== 1'b1 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL simult_swap got fb=%b rdy=%b want fb=1 rdy=1", front_bank, wr_ready);
        end
    endtask

    task automatic test_swap_edge_read();
        wr_en = 1; wr_addr = 7; wr_data = 24'h123456;   // bank 0
        tick();
        wr_addr = AW'(NPIX); wr_data = 24'h777777;     // out of range
        tick();
        wr_en = 0; wr_frame_done = 1;
        tick();
        wr_frame_done = 0;
        rd_frame_start = 1; rd_en = 1; rd_addr = 7;
        tick();
        rd_frame_start = 0;
        checks++;
        if (rd_data !== 24'hABCDEF || front_bank !== 1'b0) begin
            failures++;
            $display("FAIL swap_edge_read got data=%h fb=%b want abcdef fb=0", rd_data, front_bank);
        end
        tick();
        checks++;
        if (rd_data !== 24'h123456) begin
            failures++; $display("FAIL new_front_read got=%h want=123456", rd_data);
        end
        rd_addr = AW'(NPIX);
        tick();
        rd_en = 0;
        checks++;
        if (rd_data !== '0) begin
            failures++; $display("FAIL oob_read got=%h want=0", rd_data);
        end
    endtask

    task automatic test_async_reset();
        if (m_front == 1'b0) begin
            wr_frame_done = 1; tick(); wr_frame_done = 0;
            rd_frame_start = 1; tick(); rd_frame_start = 0;
        end
        rd_en = 1; rd_addr = 7; wr_frame_done = 1;
        tick();
        rd_en = 0; wr_frame_done = 0;
        checks++;
        if (wr_ready !== 1'b0 || front_bank !== 1'b1 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got rdy=%b fb=%b rv=%b want 0 1 1", wr_ready, front_bank, rd_valid);
        end
        #2 rst = 1;
        #1;
        model_reset();
        checks++;
        if ({wr_ready, front_bank, frame_valid, rd_valid} !== 4'b1000 || rd_data !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b data=%h want=1000 data=0", {wr_ready, front_bank, frame_valid, rd_valid}, rd_data);
        end
        @(negedge clk); rst = 0;
        rd_frame_start = 1;
        tick();
        rd_frame_start = 0;
        checks++;
        if (front_bank !== 1'b0 || frame_valid !== 1'b0 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL no_swap_after_reset got fb=%b fv=%b rdy=%b", front_bank, frame_valid, wr_ready);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return AW'(NPIX + int'($urandom_range(0, 3)));
        return AW'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en          = ($urandom_range(0, 2) != 0);
            wr_addr        = rand_addr();
            wr_data        = PW'($urandom);
            wr_frame_done  = ($urandom_range(0, 9) == 0);
            rd_frame_start = ($urandom_range(0, 5) == 0);
            rd_en          = ($urandom_range(0, 1) != 0);
            rd_addr        = rand_addr();
            tick();
            checks++;
            if (rd_valid !== m_rvalid || wr_ready !== !m_pend ||
                front_bank !== m_front || frame_valid !== m_fv) begin
                failures++;
                $display("FAIL rand_ctrl cyc=%0d got rv/rdy/fb/fv=%b%b%b%b want %b%b%b%b", n,
                         rd_valid, wr_ready, front_bank, frame_valid, m_rvalid, !m_pend, m_front, m_fv);
            end
            if (m_known) begin
                checks++;
                if (rd_data !== m_rdata) begin
                    failures++;
                    $display("FAIL rand_data cyc=%0d got=%h want=%h", n, rd_data, m_rdata);
                end
            end
`ifdef FB_OVERRUN_CNT_EN
            checks++;
            if (int'(overrun_cnt) !== m_ovr) begin
                failures++;
                $display("FAIL rand_overrun cyc=%0d got=%0d want=%0d", n, overrun_cnt, m_ovr);
            end
`endif
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_write_swap();
        test_pending_write();
        test_simultaneous();
        test_swap_edge_read();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
